aer_spike_fifo_param: RTL and testbench

//  Parametrised AER spike buffer between a spiking layer (e.g. conv1) and its consumer (e.g. pool).

---
 rtl/aer_spike_fifo_param.sv | 124 ++++++++++++
 tb/tb_aer_spike_fifo_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_fifo_param.sv
// AER spike buffer: inferred circular FIFO with a request/valid single-pop read engine,
// overflow drop counting, fill-level flags and accepted/dropped spike statistics.
module aer_spike_fifo_param #(
  parameter int DATA_W   = 18,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int AFULL_TH = 56,
  parameter int CNT_W    = 32,
  parameter int DROP_W   = 16
) (
  input  logic              work_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] aer_data_i,
  input  logic              spike_emit_i,
  input  logic              read_req,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] aer_data_o,
  output logic              aer_valid_o,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic [AW:0]       fill_level,
  output logic [CNT_W-1:0]  spike_cnt,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_WAIT    = 4'b0010,
    S_POP     = 4'b0100,
    S_PRESENT = 4'b1000
  } state_e;

  localparam logic [AW:0] LV_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LV_AFULL = (AW+1)'(AFULL_TH);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         level_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic [CNT_W-1:0]    spike_q;
  logic [DROP_W-1:0]   drop_q;
  logic                wr_en, drop_en, pop;

  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == LV_FULL);
  assign almost_full = (level_q >= LV_AFULL);
  assign fill_level  = level_q;
  assign aer_data_o  = data_q;
  assign aer_valid_o = valid_q;
  assign spike_cnt   = spike_q;
  assign drop_cnt    = drop_q;

  // Fullness is judged before the edge, so a same-edge pop never makes room for a write.
  assign wr_en   = spike_emit_i & ~fifo_full;
  assign drop_en = spike_emit_i &  fifo_full;

  always_comb begin
    state_d = S_IDLE;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:    state_d = read_req ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!read_req)        state_d = S_IDLE;
        else if (!fifo_empty) state_d = S_POP;
        else                  state_d = S_WAIT;
      end
      S_POP: begin
        pop     = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Storage carries no reset; occupancy is governed entirely by the pointers and level.
  always_ff @(posedge work_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= aer_data_i;
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= pop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= '0;
      drop_q  <= '0;
    end else if (cnt_clr) begin
      spike_q <= '0;
      drop_q  <= '0;
    end else begin
      if (wr_en) spike_q <= spike_q + 1'b1;
      if (drop_en && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_aer_spike_fifo_param.sv
// Bench for aer_spike_fifo_param: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_aer_spike_fifo_param;

  localparam int DW = 18;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          emit = 1'b0;
  logic          req = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] dout;
  logic          vld, emp, ful, afull;
  logic [6:0]    lvl;
  logic [31:0]   spk;
  logic [15:0]   drp;

  aer_spike_fifo_param dut (
    .work_clk(clk), .rst_n(rst_n), .aer_data_i(din), .spike_emit_i(emit),
    .read_req(req), .cnt_clr(clr), .aer_data_o(dout), .aer_valid_o(vld),
    .fifo_empty(emp), .fifo_full(ful), .almost_full(afull), .fill_level(lvl),
    .spike_cnt(spk), .drop_cnt(drp)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy is a queue, the read engine is timestamp-like countdown.
  logic [DW-1:0] mq[$];
  int            m_busy;
  bit            m_wait;
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic [31:0]   m_spk;
  logic [15:0]   m_drp;

  logic [DW-1:0] pops[$];
  int            vcount = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    mq.delete();
    m_busy = 0; m_wait = 0; m_valid = 0; m_data = '0; m_spk = '0; m_drp = '0;
  endtask

  task automatic model_step;
    bit full_pre, empty_pre, do_pop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    full_pre  = (mq.size() == DEPTH);
    empty_pre = (mq.size() == 0);
    do_pop    = (m_busy == 2);
    m_valid   = do_pop;
    if (do_pop) m_data = mq.pop_front();
    if (emit) begin
      if (full_pre) begin
        if (m_drp != 16'hFFFF) m_drp++;
      end else begin
        mq.push_back(din);
        m_spk++;
      end
    end
    if (clr) begin m_spk = '0; m_drp = '0; end
    if (m_busy > 0) m_busy--;
    else if (m_wait) begin
      if (!req) m_wait = 0;
      else if (!empty_pre) begin m_wait = 0; m_busy = 2; end
    end else if (req) m_wait = 1;
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (vld) begin pops.push_back(dout); vcount++; end
    chk("valid", vld, m_valid);
    chk("data", dout, m_data);
    chk("empty", emp, mq.size() == 0);
    chk("full", ful, mq.size() == DEPTH);
    chk("afull", afull, mq.size() >= 56);
    chk("level", lvl, mq.size());
    chk("spike_cnt", spk, m_spk);
    chk("drop_cnt", drp, m_drp);
  end

  initial begin
    int base;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1: reset values, then async reset while popping
    chk("t1_empty", emp, 1);
    chk("t1_full", ful, 0);
    chk("t1_afull", afull, 0);
    chk("t1_cnt", spk, 0);
    for (int i = 0; i < 3; i++) begin emit = 1; din = 18'(i + 1); tick(); end
    emit = 0; req = 1;
    tick(); tick();
    rst_n = 1'b0; req = 0;
    model_reset();
    @(negedge clk);
    chk("t1_rst_valid", vld, 0);
    chk("t1_rst_empty", emp, 1);
    chk("t1_rst_level", lvl, 0);
    chk("t1_rst_spk", spk, 0);
    chk("t1_rst_drp", drp, 0);
    #1;
    tick();
    rst_n = 1'b1;
    tick();

    // T2: single event, request two edges later
    emit = 1; din = 18'h3A5C1; tick();
    emit = 0; tick();
    req = 1; tick(); tick();
    chk("t2_level_pre", lvl, 1);
    chk("t2_valid_pre", vld, 0);
    tick();
    chk("t2_valid", vld, 1);
    chk("t2_data", dout, 18'h3A5C1);
    chk("t2_level_post", lvl, 0);
    req = 0; tick();
    chk("t2_valid_low", vld, 0);
    tick(); tick();

    // T3: 100 events with interleaved pops, order across pointer wrap
    pops.delete();
    req = 1;
    for (int i = 0; i < 100; i++) begin
      emit = 1; din = 18'(i * 7 + 5); tick();
      emit = 0; tick();
    end
    for (int c = 0; c < 2000 && pops.size() < 100; c++) tick();
    req = 0;
    tick(); tick(); tick(); tick();
    chk("t3_count", pops.size(), 100);
    for (int k = 0; k < 100 && k < pops.size(); k++) chk("t3_order", pops[k], 18'(k * 7 + 5));
    chk("t3_empty", emp, 1);

    // T4: overflow, almost_full onset, saturating statistics
    clr = 1; tick(); clr = 0;
    chk("t4_clr_spk", spk, 0);
    chk("t4_clr_drp", drp, 0);
    for (int k = 1; k <= 70; k++) begin
      emit = 1; din = 18'(k); tick();
      chk("t4_afull", afull, k >= 56);
      chk("t4_full", ful, k >= 64);
    end
    emit = 0;
    chk("t4_spk", spk, 64);
    chk("t4_drp", drp, 6);
    chk("t4_level", lvl, 64);
    emit = 1; clr = 1; tick();
    emit = 0; clr = 0;
    chk("t4_clrdrop_drp", drp, 0);
    chk("t4_clrdrop_spk", spk, 0);

    // T6a: full, write and pop on the same edge: write still dropped
    req = 1; tick(); tick();
    emit = 1; din = 18'h15555; tick();
    emit = 0; req = 0;
    chk("t6_full_level", lvl, 63);
    chk("t6_full_drp", drp, 1);
    chk("t6_full_valid", vld, 1);
    chk("t6_full_data", dout, 18'd1);
    tick(); tick();

    // T6b: level 10, write and pop on the same edge
    do_reset();
    for (int k = 0; k < 10; k++) begin emit = 1; din = 18'(200 + k); tick(); end
    emit = 0;
    chk("t6_lvl10", lvl, 10);
    req = 1; tick(); tick();
    emit = 1; din = 18'h2AAAA; tick();
    emit = 0; req = 0;
    chk("t6_simul_level", lvl, 10);
    chk("t6_simul_valid", vld, 1);
    chk("t6_simul_data", dout, 18'd200);
    tick(); tick();

    // T5: request on empty FIFO, then cancel
    do_reset();
    base = vcount;
    req = 1;
    for (int i = 0; i < 5; i++) tick();
    req = 0;
    tick(); tick(); tick();
    chk("t5_no_pulse", vcount - base, 0);
    emit = 1; din = 18'h00ABC; tick();
    emit = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_idle_level", lvl, 1);
    chk("t5_no_pulse2", vcount - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
